instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Instruction fetch stage; the reader side of the 16x16 asynchronous-read program ROM.
//  - Owns the program counter and drives rom_addr.
//  - Captures rom_data into an instruction register (IR).
//  - Hands the IR to decode over a valid/ready handshake; supports backpressure, branch redirect and an enable gate.
// PARAMETERS
//  ADDR_W    4       PC / ROM address width (ROM depth = 2**ADDR_W)
//  INST_W    16      instruction width
//  RESET_PC  0       PC value after reset
//  CNT_W     16      width of the retired-fetch counter
// PORTS
//  clk             in   1       rising-edge clock (single clock domain)
//  rst_n           in   1       asynchronous active-low reset
//  fetch_en        in   1       1 = new fetches allowed
//  rom_addr        out  ADDR_W  ROM address; combinational copy of pc
//  rom_data        in   INST_W  ROM instruction, valid in the same cycle as rom_addr
//  redirect_valid  in   1       branch/jump request
//  redirect_addr   in   ADDR_W  target PC for the redirect
//  ir              out  INST_W  fetched instruction
//  ir_pc           out  ADDR_W  address that ir was fetched from
//  ir_valid        out  1       ir holds an undelivered instruction
//  ir_ready        in   1       decode accepts ir when ir_valid && ir_ready
//  halted          out  1       fetch stopped by the wrap rule (FETCH_HALT_ON_WRAP_EN only; else 0)
//  fetch_cnt       out  CNT_W   instructions accepted by decode, saturating
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - pc=RESET_PC, ir=0, ir_pc=0, ir_valid=0, halted=0, fetch_cnt=0.
//   - rom_addr = RESET_PC.
//  Definitions:
//   - accept = ir_valid && ir_ready.
//   - slot_free = !ir_valid || ir_ready.
//  Each clock, in priority order:
//   1. redirect_valid=1: pc<=redirect_addr; ir_valid<=0 (squash, even if accepted this cycle); no fetch this cycle; clears halted.
//   2. Else if fetch_en && slot_free && !halted: ir<=rom_data; ir_pc<=pc; ir_valid<=1; pc<=pc+1.
//   3. Else if accept: ir_valid<=0; pc, ir and ir_pc hold.
//   4. Else: hold all state (stall).
//  Latency and throughput:
//   - pc to ir_valid: 1 cycle.
//   - First instruction after reset: ir_valid=1 on the first edge with fetch_en=1.
//   - Throughput: 1 instr/cycle when ir_ready=1.
//  Arithmetic and counting:
//   - pc+1 is modulo 2**ADDR_W: 15 -> 0 wraps silently.
//   - fetch_cnt increments on each accept not squashed by redirect; saturates at all-ones.
//  Other rules:
//   - fetch_en=0: an already-valid ir is still delivered; no refill.
//   - Stall (ir_valid && !ir_ready): ir, ir_pc and ir_valid stay stable; decode may rely on this.
//   - A redirect in the same cycle as an accept squashes the accepted instruction: no count, ir_valid<=0.
//   - Reset asserted mid-stall drops ir immediately (async); the first fetch after release is from RESET_PC.
// CONFIGURATION
//  FETCH_HALT_ON_WRAP_EN defined:
//   - A fetch from pc = 2**ADDR_W-1 completes normally, then sets halted<=1 (pc wraps to 0).
//   - While halted, no fetches; only redirect_valid or reset clear halted.
//  Not defined:
//   - pc wraps and fetching continues; halted is tied to 0.
// STRUCTURE
//  proc_pkg (shared package):
//   - ADDR_W/INST_W defaults.
//   - Opcode field [15:12] constants: OP_ADDI=4'b0001, OP_ADD=4'b0010, OP_OUT=4'b1111.
//   - Register field [11:9] slice constants.
//  fetch_pc (sub-module):
//   - pc register with redirect mux, increment, wrap and halt logic.
//  instr_fetch:
//   - IR, handshake, counter.
// TESTING (bench ROM model: rom_data = {4'hA, 8'h00, addr})
//  1. Reset, fetch_en=1, ir_ready=1 -> ir_pc 0,1,2,... on consecutive cycles; ir=16'hA000+pc; fetch_cnt tracks.
//  2. Hold ir_ready=0 at ir_pc=5 for 4 cycles -> ir/ir_pc stable at 5, rom_addr=6; on release ir_pc=6 next cycle.
//  3. redirect_valid, redirect_addr=3 while ir_valid at ir_pc=9 -> next cycle ir_valid=0; following cycle ir_pc=3; squashed instr not counted.
//  4. Run through pc=15 -> ir_pc 14,15,0,1 without macro; with FETCH_HALT_ON_WRAP_EN, halted=1 after 15 is fetched, no more fetches until redirect to 2 -> ir_pc=2.
//  5. fetch_en=0 with ir_valid=1 -> one more accept, then ir_valid=0 and pc frozen.
//  6. rst_n low mid-stall at ir_pc=7 -> outputs clear asynchronously; after release first ir_pc=RESET_PC.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared processor definitions: default bus widths and instruction field layout.
package proc_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int INST_W_DEF = 16;

  typedef enum logic [3:0] {
    OP_ADDI = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_OUT  = 4'b1111
  } opcode_e;

  localparam int OP_MSB = 15;
  localparam int OP_LSB = 12;
  localparam int RD_MSB = 11;
  localparam int RD_LSB = 9;

  function automatic logic [3:0] opcode_of(input logic [INST_W_DEF-1:0] inst);
    return inst[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-to-decode instruction handshake. The fetch stage is the master and decode is the slave.
interface instr_fetch_if
  import proc_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INST_W = INST_W_DEF
);
  logic [INST_W-1:0] ir;
  logic [ADDR_W-1:0] ir_pc;
  logic              ir_valid;
  logic              ir_ready;

  modport master (output ir, ir_pc, ir_valid, input ir_ready);
  modport slave  (input ir, ir_pc, ir_valid, output ir_ready);
endinterface

// File: rtl/instr_fetch_pc.sv
// Program counter with redirect mux, modulo increment and optional halt-on-wrap.
// The halt behaviour is built in when FETCH_HALT_ON_WRAP_EN is defined.
module fetch_pc
  import proc_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_redirect_valid,
  input  logic [ADDR_W-1:0] i_redirect_addr,
  input  logic              i_fetch,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_halted
);

  logic [ADDR_W-1:0] r_pc;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_pc <= RESET_PC;
    else if (i_redirect_valid) r_pc <= i_redirect_addr;
    else if (i_fetch)          r_pc <= r_pc + 1'b1;
  end

  assign o_pc = r_pc;

`ifdef FETCH_HALT_ON_WRAP_EN
  logic r_halted;

  // The fetch from the last address still completes; the halt takes effect afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     r_halted <= 1'b0;
    else if (i_redirect_valid)      r_halted <= 1'b0;
    else if (i_fetch && &r_pc)      r_halted <= 1'b1;
  end

  assign o_halted = r_halted;
`else
  assign o_halted = 1'b0;
`endif

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: it drives the ROM address, holds the instruction register and hands it to decode.
// Define FETCH_HALT_ON_WRAP_EN to stop fetching after the fetch from the top ROM address.
module instr_fetch
  import proc_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                INST_W   = INST_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_fetch_en,
  output logic [ADDR_W-1:0]    o_rom_addr,
  input  logic [INST_W-1:0]    i_rom_data,
  input  logic                 i_redirect_valid,
  input  logic [ADDR_W-1:0]    i_redirect_addr,
  instr_fetch_if.master        dec,
  output logic                 o_halted,
  output logic [CNT_W-1:0]     o_fetch_cnt
);

  logic [INST_W-1:0] r_ir;
  logic [ADDR_W-1:0] r_ir_pc;
  logic              r_ir_valid;
  logic [CNT_W-1:0]  r_fetch_cnt;

  logic [ADDR_W-1:0] w_pc;
  logic              w_halted;
  logic              w_accept;
  logic              w_slot_free;
  logic              w_fetch;

  assign w_accept    = r_ir_valid && dec.ir_ready;
  assign w_slot_free = !r_ir_valid || dec.ir_ready;
  assign w_fetch     = !i_redirect_valid && i_fetch_en && w_slot_free && !w_halted;

  fetch_pc #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_fetch_pc (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_redirect_valid (i_redirect_valid),
    .i_redirect_addr  (i_redirect_addr),
    .i_fetch          (w_fetch),
    .o_pc             (w_pc),
    .o_halted         (w_halted)
  );

  // The IR and its PC change only on a fetch, which keeps them stable across a decode stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir    <= '0;
      r_ir_pc <= '0;
    end else if (w_fetch) begin
      r_ir    <= i_rom_data;
      r_ir_pc <= w_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_ir_valid <= 1'b0;
    else if (i_redirect_valid) r_ir_valid <= 1'b0;
    else if (w_fetch)          r_ir_valid <= 1'b1;
    else if (w_accept)         r_ir_valid <= 1'b0;
  end

  // An accept in the same cycle as a redirect is squashed and does not count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_fetch_cnt <= '0;
    else if (w_accept && !i_redirect_valid && !(&r_fetch_cnt))
      r_fetch_cnt <= r_fetch_cnt + 1'b1;
  end

  assign o_rom_addr   = w_pc;
  assign dec.ir       = r_ir;
  assign dec.ir_pc    = r_ir_pc;
  assign dec.ir_valid = r_ir_valid;
  assign o_halted     = w_halted;
  assign o_fetch_cnt  = r_fetch_cnt;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch using a ROM model that returns {4'hA, 8'h00, addr}.
// The expectations cover both builds, with and without FETCH_HALT_ON_WRAP_EN.
module tb_instr_fetch;
  import proc_pkg::*;

  localparam int ADDR_W = 4;
  localparam int INST_W = 16;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              fetch_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [INST_W-1:0] rom_data;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_addr;
  logic              halted;
  logic [CNT_W-1:0]  fetch_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  instr_fetch_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) dec_if ();

  instr_fetch #(
    .ADDR_W   (ADDR_W),
    .INST_W   (INST_W),
    .RESET_PC (4'd0),
    .CNT_W    (CNT_W)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_fetch_en       (fetch_en),
    .o_rom_addr       (rom_addr),
    .i_rom_data       (rom_data),
    .i_redirect_valid (redirect_valid),
    .i_redirect_addr  (redirect_addr),
    .dec              (dec_if.master),
    .o_halted         (halted),
    .o_fetch_cnt      (fetch_cnt)
  );

  assign rom_data = {4'hA, 8'h00, rom_addr};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ir(input string tag, input logic [ADDR_W-1:0] pc, input int cnt);
    check({tag, ".valid"}, 32'(dec_if.ir_valid), 32'd1);
    check({tag, ".ir_pc"}, 32'(dec_if.ir_pc), 32'(pc));
    check({tag, ".ir"},    32'(dec_if.ir), 32'h0000_A000 + 32'(pc));
    check({tag, ".cnt"},   32'(fetch_cnt), 32'(cnt));
  endtask

`ifdef FETCH_HALT_ON_WRAP_EN
  localparam int T5_CNT = 23;
  localparam int T5_PC  = 3;
`else
  localparam int T5_CNT = 24;
  localparam int T5_PC  = 2;
`endif

  initial begin
    rst_n          = 1'b0;
    fetch_en       = 1'b1;
    dec_if.ir_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_addr  = '0;

    // Reset state
    tick();
    tick();
    check("rst.valid",    32'(dec_if.ir_valid), 32'd0);
    check("rst.ir",       32'(dec_if.ir), 32'd0);
    check("rst.ir_pc",    32'(dec_if.ir_pc), 32'd0);
    check("rst.rom_addr", 32'(rom_addr), 32'd0);
    check("rst.cnt",      32'(fetch_cnt), 32'd0);
    check("rst.halted",   32'(halted), 32'd0);
    rst_n = 1'b1;

    // 1: streaming, one instruction per cycle
    for (int k = 1; k <= 6; k++) begin
      tick();
      check_ir($sformatf("t1.%0d", k), ADDR_W'(k - 1), k - 1);
    end

    // 2: decode stall at ir_pc=5
    dec_if.ir_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_ir($sformatf("t2.stall%0d", k), 4'd5, 5);
      check($sformatf("t2.rom_addr%0d", k), 32'(rom_addr), 32'd6);
    end
    dec_if.ir_ready = 1'b1;
    tick();
    check_ir("t2.release", 4'd6, 6);

    // 3: redirect while ir_pc=9 is being accepted
    repeat (3) tick();
    check_ir("t3.pre", 4'd9, 9);
    redirect_valid = 1'b1;
    redirect_addr  = 4'd3;
    tick();
    redirect_valid = 1'b0;
    check("t3.squash.valid", 32'(dec_if.ir_valid), 32'd0);
    check("t3.squash.rom",   32'(rom_addr), 32'd3);
    check("t3.squash.cnt",   32'(fetch_cnt), 32'd9);
    tick();
    check_ir("t3.target", 4'd3, 9);

    // 4: run up to and across the top of the ROM
    repeat (11) tick();
    check_ir("t4.pc14", 4'd14, 20);
    tick();
    check_ir("t4.pc15", 4'd15, 21);
`ifdef FETCH_HALT_ON_WRAP_EN
    check("t4.halted", 32'(halted), 32'd1);
    tick();
    check("t4.drain.valid", 32'(dec_if.ir_valid), 32'd0);
    check("t4.drain.cnt",   32'(fetch_cnt), 32'd22);
    tick();
    check("t4.hold.valid",  32'(dec_if.ir_valid), 32'd0);
    check("t4.hold.halted", 32'(halted), 32'd1);
    check("t4.hold.rom",    32'(rom_addr), 32'd0);
    redirect_valid = 1'b1;
    redirect_addr  = 4'd2;
    tick();
    redirect_valid = 1'b0;
    check("t4.unhalt", 32'(halted), 32'd0);
    tick();
    check_ir("t4.resume", 4'd2, 22);
`else
    tick();
    check_ir("t4.wrap0", 4'd0, 22);
    check("t4.halted", 32'(halted), 32'd0);
    tick();
    check_ir("t4.wrap1", 4'd1, 23);
`endif

    // 5: fetch_en low still delivers the held instruction, then freezes
    fetch_en = 1'b0;
    tick();
    check("t5.valid", 32'(dec_if.ir_valid), 32'd0);
    check("t5.cnt",   32'(fetch_cnt), 32'(T5_CNT));
    check("t5.rom",   32'(rom_addr), 32'(T5_PC));
    tick();
    check("t5.frozen.valid", 32'(dec_if.ir_valid), 32'd0);
    check("t5.frozen.rom",   32'(rom_addr), 32'(T5_PC));
    check("t5.frozen.cnt",   32'(fetch_cnt), 32'(T5_CNT));

    // 6: asynchronous reset during a stall at ir_pc=7
    fetch_en        = 1'b1;
    dec_if.ir_ready = 1'b0;
    redirect_valid  = 1'b1;
    redirect_addr   = 4'd7;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick();
    check_ir("t6.stall", 4'd7, T5_CNT);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6.rst.valid", 32'(dec_if.ir_valid), 32'd0);
    check("t6.rst.ir",    32'(dec_if.ir), 32'd0);
    check("t6.rst.ir_pc", 32'(dec_if.ir_pc), 32'd0);
    check("t6.rst.rom",   32'(rom_addr), 32'd0);
    check("t6.rst.cnt",   32'(fetch_cnt), 32'd0);
    tick();
    rst_n           = 1'b1;
    dec_if.ir_ready = 1'b1;
    tick();
    check_ir("t6.first", 4'd0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
